// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word load and store requests into word-wide accesses to an
// asynchronous-read, synchronous-write data memory. Sub-word stores do a read-modify-write.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   req_valid/req_ready  request handshake; all req_* fields are latched on accept
//   req_write            1 = store, 0 = load
//   req_size             00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned         loads only: 1 zero-extend, 0 sign-extend
//   req_addr, req_wdata  byte address and right-justified store data
//   resp_valid           one-cycle completion pulse
//   resp_rdata           extended load data (0 for stores and errors)
//   resp_error           misaligned or illegal-size request, qualified by resp_valid
//   mem_*                word-aligned data-memory interface
//   busy                 high whenever the unit is not idle
module load_store_unit #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic              busy
);

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StRmwRead,
    StWrite,
    StResp
  } state_e;

  state_e state_q, state_d;

  // Latched request fields and response data.
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;  // store data; holds the merged word after RMW_READ
  logic [31:0]       rdata_q, rdata_d;
  logic              error_q, error_d;

  logic accept;
  logic req_bad;

  // Illegal size or an address not aligned to the access size.
  function automatic logic is_bad_request(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    unique case (size)
      SizeByte: bad = 1'b0;
      SizeHalf: bad = lane[0];
      SizeWord: bad = (lane != 2'b00);
      default:  bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Pick the addressed lane out of a memory word and sign/zero-extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    unique case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    unique case (size)
      SizeByte: res = {{24{~is_unsigned & b[7]}}, b};
      SizeHalf: res = {{16{~is_unsigned & h[15]}}, h};
      default:  res = word;
    endcase
    return res;
  endfunction

  // Overlay the store lane(s) of the right-justified store data onto the old memory word.
  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] res;
    res = old;
    unique case (size)
      SizeByte: begin
        unique case (lane)
          2'd0:    res[7:0]   = wdata[7:0];
          2'd1:    res[15:8]  = wdata[7:0];
          2'd2:    res[23:16] = wdata[7:0];
          default: res[31:24] = wdata[7:0];
        endcase
      end
      SizeHalf: begin
        if (lane[1]) begin
          res[31:16] = wdata[15:0];
        end else begin
          res[15:0] = wdata[15:0];
        end
      end
      default: res = wdata;
    endcase
    return res;
  endfunction

  assign accept  = req_valid && req_ready;
  assign req_bad = is_bad_request(req_size, req_addr[1:0]);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_bad) begin
            state_d = StResp;
          end else if (!req_write) begin
            state_d = StRead;
          end else if (req_size == SizeWord) begin
            state_d = StWrite;
          end else begin
            state_d = StRmwRead;
          end
        end
      end
      StRead:    state_d = StResp;
      StRmwRead: state_d = StWrite;
      StWrite:   state_d = StResp;
      StResp:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs. Memory strobes and req_ready are masked by reset so a reset landing in WRITE
  // commits nothing.
  always_comb begin
    req_ready      = (state_q == StIdle) && !reset;
    busy           = (state_q != StIdle);
    resp_valid     = (state_q == StResp);
    resp_error     = (state_q == StResp) && error_q;
    resp_rdata     = ((state_q == StResp) && !write_q) ? rdata_q : 32'h0;
    mem_memread    = ((state_q == StRead) || (state_q == StRmwRead)) && !reset;
    mem_memwrite   = (state_q == StWrite) && !reset;
    mem_addr       = '0;
    mem_write_data = 32'h0;
    if ((state_q == StRead) || (state_q == StRmwRead) || (state_q == StWrite)) begin
      mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
    end
    if (state_q == StWrite) begin
      mem_write_data = wdata_q;
    end
  end

  // Datapath next-state.
  always_comb begin
    write_d = write_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    error_d = error_q;
    if (accept) begin
      write_d = req_write;
      size_d  = req_size;
      uns_d   = req_unsigned;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      rdata_d = 32'h0;
      error_d = req_bad;
    end
    if (state_q == StRead) begin
      rdata_d = load_extract(mem_read_data, size_q, addr_q[1:0], uns_q);
    end
    if (state_q == StRmwRead) begin
      wdata_d = store_merge(mem_read_data, wdata_q, size_q, addr_q[1:0]);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_q <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      error_q <= 1'b0;
    end else begin
      write_q <= write_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [7:0]  mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_memread;
  logic        mem_memwrite;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Data memory seen by the DUT, and the reference model's view of it.
  logic [31:0] dmem     [64];
  logic [31:0] init_val [64];
  logic [31:0] ref_mem  [64];
  logic        mem_init;

  load_store_unit #(.ADDR_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_error     (resp_error),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .mem_memread    (mem_memread),
    .mem_memwrite   (mem_memwrite),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  assign mem_read_data = dmem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) dmem[i] <= init_val[i];
    end else if (mem_memwrite) begin
      dmem[mem_addr[7:2]] <= mem_write_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One full transaction, checked against a model built from the access rules.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [7:0] addr, input logic [31:0] wd,
                        output logic [31:0] rdata);
    int          idx, lane, sh, n, cyc, rd_n, wr_n, exp_lat, exp_rd, exp_wr;
    logic        err;
    logic [31:0] old, v, mask, exp_rdata, exp_word;
    idx  = int'(addr) / 4;
    lane = int'(addr) % 4;
    err  = (sz == 2'd3) || (sz == 2'd1 && (lane % 2) != 0) || (sz == 2'd2 && lane != 0);
    old  = ref_mem[idx];
    exp_rdata = 32'h0;
    exp_word  = old;
    if (sz == 2'd0) begin
      sh = 8 * lane;  mask = 32'hFF;
    end else if (sz == 2'd1) begin
      sh = 16 * (lane / 2);  mask = 32'hFFFF;
    end else begin
      sh = 0;  mask = 32'hFFFF_FFFF;
    end
    if (!err && !wr) begin
      v = (old >> sh) & mask;
      if (!uns && sz == 2'd0 && v >= 32'h80)   v = v + 32'hFFFF_FF00;
      if (!uns && sz == 2'd1 && v >= 32'h8000) v = v + 32'hFFFF_0000;
      exp_rdata = v;
    end
    if (!err && wr) exp_word = (old & ~(mask << sh)) | ((wd & mask) << sh);
    exp_lat = err ? 1 : (wr && sz != 2'd2) ? 3 : 2;
    exp_rd  = (!err && (!wr || sz != 2'd2)) ? 1 : 0;
    exp_wr  = (!err && wr) ? 1 : 0;

    @(negedge clk);
    req_valid = 1'b1;  req_write = wr;  req_size = sz;  req_unsigned = uns;
    req_addr  = addr;  req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    // Scramble the request bus to make sure the unit works from latched fields.
    req_valid = 1'b0;  req_write = $urandom;  req_size = $urandom;  req_unsigned = $urandom;
    req_addr  = $urandom;  req_wdata = $urandom;
    cyc = 1;  rd_n = 0;  wr_n = 0;
    while (!resp_valid && cyc < 10) begin
      check("busy_ready", 32'(req_ready), 32'd0);
      check("rd_and_wr", 32'(mem_memread && mem_memwrite), 32'd0);
      if (mem_memread) begin
        rd_n++;
        check("rd_addr", 32'(mem_addr), 32'(idx * 4));
      end
      if (mem_memwrite) begin
        wr_n++;
        check("wr_addr", 32'(mem_addr), 32'(idx * 4));
        check("wr_data", mem_write_data, exp_word);
      end
      @(negedge clk);
      cyc++;
    end
    check("latency", 32'(cyc), 32'(exp_lat));
    check("resp_error", 32'(resp_error), 32'(err));
    check("resp_rdata", resp_rdata, exp_rdata);
    check("rd_cycles", 32'(rd_n), 32'(exp_rd));
    check("wr_cycles", 32'(wr_n), 32'(exp_wr));
    check("resp_mem_idle", {mem_write_data[23:0], mem_addr}, 32'h0);
    check("resp_strobes", 32'({mem_memread, mem_memwrite}), 32'd0);
    ref_mem[idx] = exp_word;
    check("mem_word", dmem[idx], ref_mem[idx]);
    rdata = resp_rdata;
  endtask

  initial begin
    logic [31:0] rd;
    int          cyc;
    int          n;
    logic        seen;

    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int          cyc;
    int          n;
    logic        seen;

    reset = 1'b1;  mem_init = 1'b1;  req_valid = 1'b0;  req_write = 1'b0;  req_size = 2'b00;
    req_unsigned = 1'b0;  req_addr = 8'h0;  req_wdata = 32'h0;
    for (int i = 0; i < 64; i++) begin
      init_val[i] = $urandom;
      ref_mem[i]  = init_val[i];
    end

    // Reset behaviour.
    @(negedge clk);
    check("rst_ready_low", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;  mem_init = 1'b0;
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp", 32'({resp_valid, resp_error}), 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_mem", {mem_write_data[23:0], mem_addr}, 32'h0);
    check("rst_strobes", 32'({mem_memread, mem_memwrite}), 32'd0);

    // Word store then word load.
    do_req(1'b1, 2'd2, 1'b0, 8'h10, 32'hDEAD_BEEF, rd);
    check("sw_mem", dmem[4], 32'hDEAD_BEEF);
    do_req(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, rd);
    check("lw_data", rd, 32'hDEAD_BEEF);

    // Byte store by read-modify-write, then byte loads.
    do_req(1'b1, 2'd0, 1'b0, 8'h11, 32'h1234_56A5, rd);
    check("sb_mem", dmem[4], 32'hDEAD_A5EF);
    do_req(1'b0, 2'd0, 1'b0, 8'h11, 32'h0, rd);
    check("lb_signed", rd, 32'hFFFF_FFA5);
    do_req(1'b0, 2'd0, 1'b1, 8'h11, 32'h0, rd);
    check("lbu", rd, 32'h0000_00A5);

    // Half loads from the upper lane.
    do_req(1'b0, 2'd1, 1'b0, 8'h12, 32'h0, rd);
    check("lh_signed", rd, 32'hFFFF_DEAD);
    do_req(1'b0, 2'd1, 1'b1, 8'h12, 32'h0, rd);
    check("lhu", rd, 32'h0000_DEAD);

    // Misaligned and illegal-size requests.
    do_req(1'b0, 2'd2, 1'b0, 8'h13, 32'h0, rd);
    check("lw_misaligned_rdata", rd, 32'h0);
    do_req(1'b0, 2'd1, 1'b0, 8'h11, 32'h0, rd);
    check("lh_misaligned_rdata", rd, 32'h0);
    do_req(1'b1, 2'd3, 1'b0, 8'h14, 32'h5555_5555, rd);

    // Reset landing in the WRITE cycle of a byte store.
    @(negedge clk);
    req_valid = 1'b1;  req_write = 1'b1;  req_size = 2'd0;  req_unsigned = 1'b0;
    req_addr  = 8'h21;  req_wdata = 32'h0000_005A;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!mem_memwrite && n < 5) begin
      @(negedge clk);
      n++;
    end
    check("rstw_reach_write", 32'(mem_memwrite), 32'd1);
    reset = 1'b1;
    #1;
    check("rstw_memwrite", 32'(mem_memwrite), 32'd0);
    check("rstw_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("rstw_idle", 32'(busy), 32'd0);
    reset = 1'b0;
    #1;
    check("rstw_ready_after", 32'(req_ready), 32'd1);
    check("rstw_rdata", resp_rdata, 32'h0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    check("rstw_no_resp", 32'(seen), 32'd0);
    check("rstw_mem_kept", dmem[8], ref_mem[8]);

    // Request held valid across a busy load.
    @(negedge clk);
    req_valid = 1'b1;  req_write = 1'b0;  req_size = 2'd2;  req_unsigned = 1'b0;
    req_addr  = 8'h10;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    req_size = 2'd0;  req_unsigned = 1'b1;  req_addr = 8'h11;
    cyc = 1;  seen = 1'b0;
    while (!resp_valid && cyc < 10) begin
      if (req_ready) seen = 1'b1;
      @(negedge clk);
      cyc++;
    end
    if (req_ready) seen = 1'b1;
    check("hold_ready_busy", 32'(seen), 32'd0);
    check("hold_lat1", 32'(cyc), 32'd2);
    check("hold_rdata1", resp_rdata, 32'hDEAD_A5EF);
    @(negedge clk);
    check("hold_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (!resp_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("hold_lat2", 32'(cyc), 32'd2);
    check("hold_rdata2", resp_rdata, 32'h0000_00A5);

    // Randomized traffic over a small window so loads often hit earlier stores.
    for (int t = 0; t < 300; t++) begin
      logic [1:0] sz;
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_req(1'($urandom), sz, 1'($urandom), 8'($urandom_range(0, 31)), $urandom, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
